uart_tx_arbiter: RTL

- Shares one 8N1 UART transmitter (tx_start / tx_data / tx_busy handshake) among NUM_REQ byte-stream requesters.
- Grants round-robin at packet granularity: once a requester wins, it owns the transmitter until its byte flagged req_last is fully sent, so packets never interleave.
- Sits between the message sources and the UART TX in the loopback design.

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART TX handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;

  // Message sources plus the UART TX busy flag
  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant_valid, grant_id, tx_start, tx_data
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant_valid, grant_id, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin arbiter for one 8N1 UART TX (optional hold timeout: UART_ARB_HOLD_TIMEOUT_EN)
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  ,
  parameter int HOLD_TIMEOUT = 1024
`endif
) (
  input  logic              clk,
  input  logic              rst,
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  output logic              timeout_evt,
`endif
  uart_tx_arbiter_if.slave  bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_ACK    = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;

  logic [2:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic               grant_valid_q;
  logic [ID_W-1:0]    grant_id_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               last_q;
  logic [NUM_REQ-1:0] req_ready_c;
  logic               found;
  logic [ID_W-1:0]    winner;
  logic               xfer;
  logic [7:0]         cur_byte;
  logic [ID_W-1:0]    next_ptr;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
  logic [15:0]        hold_cnt;
`endif

  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.req_ready   = req_ready_c;

  // Only the owner may hand over a byte, and only while the UART is idle
  always_comb begin
    req_ready_c = '0;
    if (state == S_ISSUE && !bus.tx_busy) begin
      req_ready_c[grant_id_q] = 1'b1;
    end
  end

  assign xfer     = (state == S_ISSUE) && bus.req_valid[grant_id_q] && !bus.tx_busy;
  assign cur_byte = bus.req_data[int'(grant_id_q)*8 +: 8];
  assign next_ptr = ID_W'((int'(grant_id_q) + 1) % NUM_REQ);

  // Round-robin search starting at rr_ptr; the last owner sits at the lowest priority
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  // Packet-lock state machine: grant, hand one byte to the UART, wait it out, repeat until last
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'd0;
      last_q        <= 1'b0;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
      hold_cnt      <= 16'd0;
      timeout_evt   <= 1'b0;
`endif
    end else begin
`ifdef UART_ARB_HOLD_TIMEOUT_EN
      timeout_evt <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_valid_q <= 1'b1;
            grant_id_q    <= winner;
            state         <= S_ISSUE;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
            hold_cnt      <= 16'd0;
`endif
          end
        end
        S_ISSUE: begin
          if (xfer) begin
            tx_data_q  <= cur_byte;
            tx_start_q <= 1'b1;
            last_q     <= bus.req_last[grant_id_q];
            state      <= S_LAUNCH;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
            hold_cnt   <= 16'd0;
          end else if (hold_cnt == 16'(HOLD_TIMEOUT - 1)) begin
            // Stalled owner: release exactly as if its last byte had gone out
            grant_valid_q <= 1'b0;
            rr_ptr        <= next_ptr;
            timeout_evt   <= 1'b1;
            state         <= S_IDLE;
          end else if (!bus.req_valid[grant_id_q]) begin
            hold_cnt <= hold_cnt + 16'd1;
`endif
          end
        end
        S_LAUNCH: begin
          tx_start_q <= 1'b0;
          state      <= S_ACK;
        end
        S_ACK: begin
          // Busy rises one cycle after the start pulse; do not mistake the gap for completion
          if (bus.tx_busy) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!bus.tx_busy) begin
            if (last_q) begin
              grant_valid_q <= 1'b0;
              rr_ptr        <= next_ptr;
              state         <= S_IDLE;
            end else begin
              state <= S_ISSUE;
`ifdef UART_ARB_HOLD_TIMEOUT_EN
              hold_cnt <= 16'd0;
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
